hicore_plic_claimer: RTL and testbench

ICB initiator that services the PLIC's external-interrupt output in hardware. On `plic_ext_irq` it issues a claim read to the PLIC claim/complete register and presents the returned interrupt ID to a local consumer. When the consumer signals completion, it writes the same ID back to the PLIC. It sits beside the PLIC on the peripheral ICB fabric and drives the PLIC's ICB command port as a second bus master.

---
 rtl/hicore_plic_claimer.sv | 121 ++++++++++++
 tb/tb_hicore_plic_claimer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hicore_plic_claimer.sv
// Hardware PLIC claim/complete engine: claims the pending interrupt over ICB,
// hands the ID to a local consumer, then writes it back once the consumer is done.
`timescale 1ns/1ps
module hicore_plic_claimer #(
  parameter int                   ADDR_SIZE    = 32,
  parameter int                   REG_SIZE     = 32,
  parameter int                   ID_WIDTH     = 2,
  parameter logic [ADDR_SIZE-1:0] CLAIM_ADDR   = 32'h0C20_0004,
  parameter int                   GUARD_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  plic_ext_irq,
  output logic                  icb_cmd_valid,
  input  logic                  icb_cmd_ready,
  output logic                  icb_cmd_read,
  output logic [ADDR_SIZE-1:0]  icb_cmd_addr,
  output logic [REG_SIZE-1:0]   icb_cmd_wdata,
  output logic [REG_SIZE/8-1:0] icb_cmd_wmask,
  input  logic                  icb_rsp_valid,
  output logic                  icb_rsp_ready,
  input  logic [REG_SIZE-1:0]   icb_rsp_rdata,
  input  logic                  icb_rsp_err,
  output logic [ID_WIDTH-1:0]   irq_id,
  output logic                  irq_id_valid,
  input  logic                  irq_done,
  output logic                  busy,
  output logic [7:0]            err_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    CLAIM_CMD,
    CLAIM_RSP,
    HOLD,
    CMPL_CMD,
    CMPL_RSP,
    GUARD
  } state_t;

  // Counter is loaded one short so GUARD lasts exactly GUARD_CYCLES cycles.
  localparam logic [3:0] GUARD_LOAD = 4'(GUARD_CYCLES - 1);

  state_t              state, state_nxt;
  logic [3:0]          guard_cnt, guard_cnt_nxt;
  logic [ID_WIDTH-1:0] id_q, id_nxt;
  logic [7:0]          err_q, err_nxt;
  logic [ID_WIDTH-1:0] rsp_id;
  logic [7:0]          err_inc;
  logic                unused_rdata;

  assign rsp_id       = icb_rsp_rdata[ID_WIDTH-1:0];
  assign unused_rdata = ^icb_rsp_rdata[REG_SIZE-1:ID_WIDTH];
  assign err_inc      = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      guard_cnt <= '0;
      id_q      <= '0;
      err_q     <= '0;
    end else begin
      state     <= state_nxt;
      guard_cnt <= guard_cnt_nxt;
      id_q      <= id_nxt;
      err_q     <= err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    guard_cnt_nxt = guard_cnt;
    id_nxt        = id_q;
    err_nxt       = err_q;
    case (state)
      IDLE:      if (enable && plic_ext_irq) state_nxt = CLAIM_CMD;
      CLAIM_CMD: if (icb_cmd_ready) state_nxt = CLAIM_RSP;
      CLAIM_RSP: begin
        if (icb_rsp_valid) begin
          // Errored or spurious (ID 0) claims skip the consumer and the write-back.
          if (icb_rsp_err || rsp_id == '0) begin
            if (icb_rsp_err) err_nxt = err_inc;
            state_nxt     = GUARD;
            guard_cnt_nxt = GUARD_LOAD;
          end else begin
            id_nxt    = rsp_id;
            state_nxt = HOLD;
          end
        end
      end
      HOLD:      if (irq_done) state_nxt = CMPL_CMD;
      CMPL_CMD:  if (icb_cmd_ready) state_nxt = CMPL_RSP;
      CMPL_RSP: begin
        if (icb_rsp_valid) begin
          if (icb_rsp_err) err_nxt = err_inc;
          state_nxt     = GUARD;
          guard_cnt_nxt = GUARD_LOAD;
        end
      end
      GUARD: begin
        if (guard_cnt == '0) state_nxt = IDLE;
        else guard_cnt_nxt = guard_cnt - 4'd1;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  // All outputs decode registered state only, so ICB inputs never reach ICB outputs combinationally.
  assign icb_cmd_valid = (state == CLAIM_CMD) || (state == CMPL_CMD);
  assign icb_cmd_read  = (state == CLAIM_CMD);
  assign icb_cmd_addr  = icb_cmd_valid ? CLAIM_ADDR : '0;
  assign icb_cmd_wdata = (state == CMPL_CMD) ? {{(REG_SIZE-ID_WIDTH){1'b0}}, id_q} : '0;
  assign icb_cmd_wmask = (state == CMPL_CMD) ? {(REG_SIZE/8){1'b1}} : '0;
  assign icb_rsp_ready = (state == CLAIM_RSP) || (state == CMPL_RSP);
  assign irq_id        = id_q;
  assign irq_id_valid  = (state == HOLD);
  assign busy          = (state != IDLE);
  assign err_cnt       = err_q;

endmodule

// File: tb/tb_hicore_plic_claimer.sv
// Randomized self-checking bench for hicore_plic_claimer; expectations come from a
// transaction-level model of claim outcomes, write-backs and saturating error counts.
`timescale 1ns/1ps
module tb_hicore_plic_claimer;

  localparam logic [31:0] CLAIM = 32'h0C20_0004;

  logic        clk = 0;
  logic        rst = 1;
  logic        enable = 0;
  logic        plic_ext_irq = 0;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready = 0;
  logic        icb_cmd_read;
  logic [31:0] icb_cmd_addr;
  logic [31:0] icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid = 0;
  logic        icb_rsp_ready;
  logic [31:0] icb_rsp_rdata = 0;
  logic        icb_rsp_err = 0;
  logic [1:0]  irq_id;
  logic        irq_id_valid;
  logic        irq_done = 0;
  logic        busy;
  logic [7:0]  err_cnt;

  int errors = 0;
  int checks = 0;
  int model_err = 0;
  int rd_cnt = 0, wr_cnt = 0, hold_cnt = 0;

  hicore_plic_claimer dut (
    .clk(clk), .rst(rst), .enable(enable), .plic_ext_irq(plic_ext_irq),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
    .icb_cmd_read(icb_cmd_read), .icb_cmd_addr(icb_cmd_addr),
    .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
    .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err),
    .irq_id(irq_id), .irq_id_valid(irq_id_valid), .irq_done(irq_done),
    .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Bus monitor: counts command handshakes and cycles spent presenting an ID.
  always @(posedge clk) begin
    if (!rst) begin
      if (icb_cmd_valid && icb_cmd_ready) begin
        if (icb_cmd_read) rd_cnt++;
        else wr_cnt++;
      end
      if (irq_id_valid) hold_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat_add(input int a, input int b);
    return (a + b > 255) ? 255 : a + b;
  endfunction

  task automatic trigger();
    plic_ext_irq = 1;
    step();
    plic_ext_irq = 0;
  endtask

  task automatic serve_cmd(input int stall, output bit ok, output bit stable, output logic rd,
                           output logic [31:0] ad, output logic [31:0] wd, output logic [3:0] wm);
    int n = 0;
    ok = 0; stable = 1; rd = 'x; ad = 'x; wd = 'x; wm = 'x;
    while (icb_cmd_valid !== 1'b1 && n < 40) begin step(); n++; end
    if (icb_cmd_valid !== 1'b1) return;
    ok = 1; rd = icb_cmd_read; ad = icb_cmd_addr; wd = icb_cmd_wdata; wm = icb_cmd_wmask;
    for (int i = 0; i < stall; i++) begin
      step();
      if (icb_cmd_valid !== 1'b1 || icb_cmd_read !== rd || icb_cmd_addr !== ad ||
          icb_cmd_wdata !== wd || icb_cmd_wmask !== wm) stable = 0;
    end
    icb_cmd_ready = 1;
    step();
    icb_cmd_ready = 0;
    if (icb_cmd_valid !== 1'b0) stable = 0;
  endtask

  task automatic serve_rsp(input int delay, input logic [31:0] data, input logic err, output bit ok);
    int n = 0;
    ok = 0;
    while (icb_rsp_ready !== 1'b1 && n < 40) begin step(); n++; end
    if (icb_rsp_ready !== 1'b1) return;
    for (int i = 0; i < delay; i++) step();
    ok = (icb_rsp_ready === 1'b1);
    icb_rsp_valid = 1; icb_rsp_rdata = data; icb_rsp_err = err;
    step();
    icb_rsp_valid = 0; icb_rsp_rdata = 0; icb_rsp_err = 0;
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (busy !== 1'b0 && n < 60) begin step(); n++; end
    ok = (busy === 1'b0);
  endtask

  task automatic wait_hold(output bit ok);
    int n = 0;
    while (irq_id_valid !== 1'b1 && n < 20) begin step(); n++; end
    ok = (irq_id_valid === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) step();
    checks++;
    if ({icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask,
         icb_rsp_ready, irq_id, irq_id_valid, busy, err_cnt} !== '0) begin
      errors++; $display("[TB] FAIL reset_outputs: got nonzero output, addr=%0h busy=%0b err_cnt=%0d expected all 0",
                         icb_cmd_addr, busy, err_cnt);
    end
    rst = 0;
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle: busy=%0b expected 0", busy); end
    model_err = 0;
  endtask

  task automatic test_basic();
    int rd0 = rd_cnt, wr0 = wr_cnt;
    bit held = 1;
    logic [3:0] busy_seq;
    enable = 1; icb_cmd_ready = 1; icb_rsp_valid = 1; icb_rsp_rdata = 32'd2;
    trigger();
    checks++;
    if ({icb_cmd_valid, icb_cmd_read, icb_cmd_addr} !== {1'b1, 1'b1, CLAIM}) begin
      errors++; $display("[TB] FAIL basic_claim_cmd: valid=%0b read=%0b addr=%0h expected 1 1 %0h",
                         icb_cmd_valid, icb_cmd_read, icb_cmd_addr, CLAIM);
    end
    step();
    checks++;
    if ({icb_cmd_valid, icb_rsp_ready} !== 2'b01) begin
      errors++; $display("[TB] FAIL basic_claim_rsp: valid=%0b rsp_ready=%0b expected 0 1", icb_cmd_valid, icb_rsp_ready);
    end
    step();
    checks++;
    if ({irq_id_valid, irq_id, icb_rsp_ready} !== {1'b1, 2'd2, 1'b0}) begin
      errors++; $display("[TB] FAIL basic_hold: id_valid=%0b id=%0d rsp_ready=%0b expected 1 2 0",
                         irq_id_valid, irq_id, icb_rsp_ready);
    end
    repeat (4) begin step(); if (irq_id_valid !== 1'b1 || irq_id !== 2'd2) held = 0; end
    checks++;
    if (held !== 1'b1) begin errors++; $display("[TB] FAIL basic_held: held=%0b expected 1", held); end
    irq_done = 1; step(); irq_done = 0;
    checks++;
    if ({icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask, irq_id_valid} !==
        {1'b1, 1'b0, CLAIM, 32'd2, 4'hF, 1'b0}) begin
      errors++; $display("[TB] FAIL basic_cmpl_cmd: valid=%0b read=%0b wdata=%0h wmask=%0h id_valid=%0b expected 1 0 2 f 0",
                         icb_cmd_valid, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask, irq_id_valid);
    end
    step();
    step();
    busy_seq[3] = busy; step();
    busy_seq[2] = busy; step();
    busy_seq[1] = busy; step();
    busy_seq[0] = busy;
    checks++;
    if (busy_seq !== 4'b1110) begin errors++; $display("[TB] FAIL basic_guard: busy_seq=%b expected 1110", busy_seq); end
    checks++;
    if ((rd_cnt - rd0) != 1 || (wr_cnt - wr0) != 1) begin
      errors++; $display("[TB] FAIL basic_handshakes: reads=%0d writes=%0d expected 1 1", rd_cnt - rd0, wr_cnt - wr0);
    end
    icb_cmd_ready = 0; icb_rsp_valid = 0; icb_rsp_rdata = 0;
  endtask

  task automatic test_backpressure();
    bit ok, stable, rok;
    logic rd; logic [31:0] ad, wd; logic [3:0] wm;
    int rd0 = rd_cnt, wr0 = wr_cnt;
    logic [1:0] id = 2'($urandom_range(1, 3));
    trigger();
    serve_cmd(4, ok, stable, rd, ad, wd, wm);
    checks++;
    if ({ok, stable, rd, ad} !== {1'b1, 1'b1, 1'b1, CLAIM}) begin
      errors++; $display("[TB] FAIL bp_claim: ok=%0b stable=%0b read=%0b addr=%0h expected 1 1 1 %0h", ok, stable, rd, ad, CLAIM);
    end
    serve_rsp($urandom_range(0, 3), {30'd0, id}, 1'b0, rok);
    wait_hold(ok);
    checks++;
    if ({rok, ok, irq_id} !== {1'b1, 1'b1, id}) begin
      errors++; $display("[TB] FAIL bp_hold: rsp_ok=%0b hold=%0b id=%0d expected 1 1 %0d", rok, ok, irq_id, id);
    end
    irq_done = 1; step(); irq_done = 0;
    serve_cmd(4, ok, stable, rd, ad, wd, wm);
    checks++;
    if ({ok, stable, rd, wd, wm} !== {1'b1, 1'b1, 1'b0, {30'd0, id}, 4'hF}) begin
      errors++; $display("[TB] FAIL bp_cmpl: ok=%0b stable=%0b read=%0b wdata=%0h wmask=%0h expected 1 1 0 %0h f",
                         ok, stable, rd, wd, wm, id);
    end
    serve_rsp(1, 32'd0, 1'b0, rok);
    wait_idle(ok);
    checks++;
    if (!ok || (rd_cnt - rd0) != 1 || (wr_cnt - wr0) != 1) begin
      errors++; $display("[TB] FAIL bp_handshakes: idle=%0b reads=%0d writes=%0d expected 1 1 1", ok, rd_cnt - rd0, wr_cnt - wr0);
    end
  endtask

  task automatic test_spurious();
    bit ok, stable, rok;
    logic rd; logic [31:0] ad, wd; logic [3:0] wm;
    int wr0 = wr_cnt, h0 = hold_cnt;
    trigger();
    serve_cmd(0, ok, stable, rd, ad, wd, wm);
    serve_rsp(0, 32'd0, 1'b0, rok);
    wait_idle(ok);
    checks++;
    if (!ok || hold_cnt != h0 || wr_cnt != wr0) begin
      errors++; $display("[TB] FAIL spurious: idle=%0b hold_cycles=%0d writes=%0d expected 1 0 0", ok, hold_cnt - h0, wr_cnt - wr0);
    end
  endtask

  task automatic test_done_ignored();
    bit ok, stable, rok, held = 1;
    logic rd; logic [31:0] ad, wd; logic [3:0] wm;
    trigger();
    serve_cmd(0, ok, stable, rd, ad, wd, wm);
    icb_rsp_valid = 1; icb_rsp_rdata = 32'd1; irq_done = 1;
    step();
    icb_rsp_valid = 0; icb_rsp_rdata = 0; irq_done = 0;
    repeat (3) begin step(); if (irq_id_valid !== 1'b1 || icb_cmd_valid !== 1'b0) held = 0; end
    checks++;
    if (held !== 1'b1) begin errors++; $display("[TB] FAIL done_during_latch: held=%0b expected 1", held); end
    irq_done = 1; step(); irq_done = 0;
    serve_cmd(0, ok, stable, rd, ad, wd, wm);
    serve_rsp(0, 32'd0, 1'b0, rok);
    wait_idle(ok);
  endtask

  task automatic test_enable();
    bit ok, stable, rok;
    logic rd; logic [31:0] ad, wd; logic [3:0] wm;
    int rd0 = rd_cnt;
    enable = 0; plic_ext_irq = 1;
    repeat (10) step();
    checks++;
    if (busy !== 1'b0 || icb_cmd_valid !== 1'b0 || rd_cnt != rd0) begin
      errors++; $display("[TB] FAIL enable_low: busy=%0b valid=%0b reads=%0d expected 0 0 0", busy, icb_cmd_valid, rd_cnt - rd0);
    end
    plic_ext_irq = 0; enable = 1;
    trigger();
    serve_cmd(1, ok, stable, rd, ad, wd, wm);
    serve_rsp(0, 32'd3, 1'b0, rok);
    wait_hold(ok);
    enable = 0;
    repeat (2) step();
    irq_done = 1; step(); irq_done = 0;
    serve_cmd(1, ok, stable, rd, ad, wd, wm);
    checks++;
    if ({ok, rd, wd} !== {1'b1, 1'b0, 32'd3}) begin
      errors++; $display("[TB] FAIL enable_drop_hold: ok=%0b read=%0b wdata=%0h expected 1 0 3", ok, rd, wd);
    end
    serve_rsp(0, 32'd0, 1'b0, rok);
    wait_idle(ok);
    enable = 1;
  endtask

  task automatic test_random();
    bit ok, stable, rok;
    logic rd; logic [31:0] ad, wd; logic [3:0] wm;
    for (int it = 0; it < 24; it++) begin
      int rd0 = rd_cnt, wr0 = wr_cnt, h0 = hold_cnt;
      logic [1:0] id = 2'($urandom_range(0, 3));
      logic cerr = ($urandom_range(0, 3) == 0);
      logic werr = ($urandom_range(0, 3) == 0);
      bit exp_hold = !cerr && (id != 0);
      trigger();
      serve_cmd($urandom_range(0, 3), ok, stable, rd, ad, wd, wm);
      checks++;
      if ({ok, stable, rd, ad} !== {1'b1, 1'b1, 1'b1, CLAIM}) begin
        errors++; $display("[TB] FAIL rnd_claim[%0d]: ok=%0b stable=%0b read=%0b addr=%0h", it, ok, stable, rd, ad);
      end
      serve_rsp($urandom_range(0, 3), {30'd0, id}, cerr, rok);
      model_err = sat_add(model_err, int'(cerr));
      if (exp_hold) begin
        wait_hold(ok);
        checks++;
        if ({ok, irq_id} !== {1'b1, id}) begin
          errors++; $display("[TB] FAIL rnd_hold[%0d]: hold=%0b id=%0d expected 1 %0d", it, ok, irq_id, id);
        end
        if ($urandom_range(0, 1) == 1) enable = 0;
        repeat ($urandom_range(0, 5)) step();
        irq_done = 1; step(); irq_done = 0;
        serve_cmd($urandom_range(0, 3), ok, stable, rd, ad, wd, wm);
        checks++;
        if ({ok, stable, rd, wd, wm} !== {1'b1, 1'b1, 1'b0, {30'd0, id}, 4'hF}) begin
          errors++; $display("[TB] FAIL rnd_cmpl[%0d]: ok=%0b stable=%0b read=%0b wdata=%0h wmask=%0h expected id %0d",
                             it, ok, stable, rd, wd, wm, id);
        end
        serve_rsp($urandom_range(0, 2), 32'd0, werr, rok);
        model_err = sat_add(model_err, int'(werr));
      end
      wait_idle(ok);
      checks++;
      if (!ok || err_cnt !== 8'(model_err) || (hold_cnt != h0) != exp_hold ||
          (wr_cnt - wr0) != int'(exp_hold) || (rd_cnt - rd0) != 1) begin
        errors++; $display("[TB] FAIL rnd_outcome[%0d]: idle=%0b err_cnt=%0d exp %0d writes=%0d exp %0d reads=%0d",
                           it, ok, err_cnt, model_err, wr_cnt - wr0, int'(exp_hold), rd_cnt - rd0);
      end
      enable = 1;
    end
  endtask

  task automatic test_err_saturate();
    bit ok, stable, rok;
    logic rd; logic [31:0] ad, wd; logic [3:0] wm;
    int wr0 = wr_cnt, h0 = hold_cnt;
    for (int i = 0; i < 300; i++) begin
      trigger();
      serve_cmd(0, ok, stable, rd, ad, wd, wm);
      serve_rsp(0, $urandom, 1'b1, rok);
      model_err = sat_add(model_err, 1);
      wait_idle(ok);
      if (i == 99) begin
        checks++;
        if (err_cnt !== 8'(model_err)) begin
          errors++; $display("[TB] FAIL err_midway: err_cnt=%0d expected %0d", err_cnt, model_err);
        end
      end
    end
    checks++;
    if (err_cnt !== 8'd255) begin errors++; $display("[TB] FAIL err_saturate: err_cnt=%0d expected 255", err_cnt); end
    checks++;
    if (hold_cnt != h0 || wr_cnt != wr0) begin
      errors++; $display("[TB] FAIL err_no_hold: hold_cycles=%0d writes=%0d expected 0 0", hold_cnt - h0, wr_cnt - wr0);
    end
  endtask

  task automatic test_reset_mid();
    enable = 1;
    trigger();
    checks++;
    if (icb_cmd_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre: valid=%0b expected 1", icb_cmd_valid); end
    rst = 1; step(); rst = 0;
    model_err = 0;
    checks++;
    if ({icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask,
         icb_rsp_ready, irq_id, irq_id_valid, busy, err_cnt} !== '0) begin
      errors++; $display("[TB] FAIL mid_reset: valid=%0b addr=%0h rsp_ready=%0b busy=%0b err_cnt=%0d expected all 0",
                         icb_cmd_valid, icb_cmd_addr, icb_rsp_ready, busy, err_cnt);
    end
    icb_rsp_valid = 1; icb_rsp_err = 1; icb_rsp_rdata = 32'd1;
    repeat (2) step();
    icb_rsp_valid = 0; icb_rsp_err = 0; icb_rsp_rdata = 0;
    step();
    checks++;
    if ({err_cnt, busy, irq_id_valid} !== {8'(model_err), 1'b0, 1'b0}) begin
      errors++; $display("[TB] FAIL late_rsp: err_cnt=%0d busy=%0b id_valid=%0b expected 0 0 0", err_cnt, busy, irq_id_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_spurious();
    test_done_ignored();
    test_enable();
    test_random();
    test_err_saturate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
